// File: rtl/tx_scrambler_framer.sv
// 802.11a transmit data-field scrambler/framer: SERVICE, scrambled PSDU, zero tail
// and scrambled pad bits, serialized toward the convolutional encoder.
//
// state   | meaning
// IDLE    | waiting for start
// SERVICE | 16 scrambled zero bits
// DATA    | scrambled PSDU bits pulled from x/x_valid
// TAIL    | 6 unscrambled zeros, LFSR still stepping
// PAD     | num_pads scrambled zero bits
module tx_scrambler_framer #(
  parameter int          LEN_W    = 12,
  parameter int          PAD_W    = 9,
  parameter logic [6:0]  DEF_SEED = 7'b1011101
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [6:0]       seed,
  input  logic [LEN_W-1:0] len,
  input  logic [PAD_W-1:0] num_pads,
  input  logic             x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             y,
  output logic             y_valid,
  output logic             y_last,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, SERVICE, DATA, TAIL, PAD} state_t;

  state_t           state, state_nxt;
  logic [6:0]       lfsr, lfsr_nxt;
  logic [3:0]       svc_cnt, svc_cnt_nxt;
  logic [2:0]       tail_cnt, tail_cnt_nxt;
  logic [LEN_W-1:0] data_cnt, data_cnt_nxt, len_q, len_nxt;
  logic [PAD_W-1:0] pad_cnt, pad_cnt_nxt, pads_q, pads_nxt;
  logic             y_nxt, y_valid_nxt, y_last_nxt, busy_nxt;
  logic             fb;

  // lfsr[6:0] holds s[7:1]; feedback is s7 ^ s4
  assign fb      = lfsr[6] ^ lfsr[3];
  assign x_ready = (state == DATA);

  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    svc_cnt_nxt  = svc_cnt;
    tail_cnt_nxt = tail_cnt;
    data_cnt_nxt = data_cnt;
    pad_cnt_nxt  = pad_cnt;
    len_nxt      = len_q;
    pads_nxt     = pads_q;
    y_nxt        = 1'b0;
    y_valid_nxt  = 1'b0;
    y_last_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          len_nxt      = len;
          pads_nxt     = num_pads;
          lfsr_nxt     = (seed == 7'd0) ? DEF_SEED : seed;
          svc_cnt_nxt  = '0;
          tail_cnt_nxt = '0;
          data_cnt_nxt = '0;
          pad_cnt_nxt  = '0;
          state_nxt    = SERVICE;
        end
      end
      SERVICE: begin
        y_nxt       = fb;
        y_valid_nxt = 1'b1;
        lfsr_nxt    = {lfsr[5:0], fb};
        if (svc_cnt == 4'd15) begin
          svc_cnt_nxt = '0;
          state_nxt   = (len_q != '0) ? DATA : TAIL;
        end else begin
          svc_cnt_nxt = svc_cnt + 4'd1;
        end
      end
      DATA: begin
        if (x_valid) begin
          y_nxt       = x ^ fb;
          y_valid_nxt = 1'b1;
          lfsr_nxt    = {lfsr[5:0], fb};
          if (data_cnt == len_q - LEN_W'(1)) begin
            data_cnt_nxt = '0;
            state_nxt    = TAIL;
          end else begin
            data_cnt_nxt = data_cnt + LEN_W'(1);
          end
        end
      end
      TAIL: begin
        y_valid_nxt = 1'b1;
        lfsr_nxt    = {lfsr[5:0], fb};
        if (tail_cnt == 3'd5) begin
          tail_cnt_nxt = '0;
          if (pads_q != '0) begin
            state_nxt = PAD;
          end else begin
            state_nxt  = IDLE;
            y_last_nxt = 1'b1;
          end
        end else begin
          tail_cnt_nxt = tail_cnt + 3'd1;
        end
      end
      PAD: begin
        y_nxt       = fb;
        y_valid_nxt = 1'b1;
        lfsr_nxt    = {lfsr[5:0], fb};
        if (pad_cnt == pads_q - PAD_W'(1)) begin
          pad_cnt_nxt = '0;
          state_nxt   = IDLE;
          y_last_nxt  = 1'b1;
        end else begin
          pad_cnt_nxt = pad_cnt + PAD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // busy covers the y_last cycle and drops right after it
    busy_nxt = (state_nxt != IDLE) || y_last_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      lfsr     <= '0;
      svc_cnt  <= '0;
      tail_cnt <= '0;
      data_cnt <= '0;
      pad_cnt  <= '0;
      len_q    <= '0;
      pads_q   <= '0;
      y        <= 1'b0;
      y_valid  <= 1'b0;
      y_last   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      svc_cnt  <= svc_cnt_nxt;
      tail_cnt <= tail_cnt_nxt;
      data_cnt <= data_cnt_nxt;
      pad_cnt  <= pad_cnt_nxt;
      len_q    <= len_nxt;
      pads_q   <= pads_nxt;
      y        <= y_nxt;
      y_valid  <= y_valid_nxt;
      y_last   <= y_last_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tx_scrambler_framer.sv
// Directed bench for tx_scrambler_framer: reference-sequence vectors, seed
// substitution, x_valid gaps, descrambler loopback and mid-frame reset.
module tb_tx_scrambler_framer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  seed = '0;
  logic [11:0] len = '0;
  logic [8:0]  num_pads = '0;
  logic        x = 1'b0;
  logic        x_valid = 1'b0;
  logic        x_ready, y, y_valid, y_last, busy;

  tx_scrambler_framer dut (
    .Clk(Clk), .Reset(Reset), .start(start), .seed(seed), .len(len),
    .num_pads(num_pads), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .y(y), .y_valid(y_valid), .y_last(y_last), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit psdu[4096];
  bit got_q[$];
  bit exp_q[$];
  bit ref_q[$];
  int last_idx, n_idle, first_c, last_c;
  bit timed_out, busy_bad, busy_after;

  // Runs one frame; called at a negedge with the DUT idle.
  task automatic run_frame(input logic [6:0] sd, input int ln, input int np,
                           input bit gap, input bit glitch);
    int  di = 0;
    int  c = 0;
    bit  done = 0;
    got_q.delete();
    last_idx = -1; n_idle = 0; first_c = -1; last_c = -1;
    busy_bad = 0; timed_out = 0;
    seed = sd; len = ln[11:0]; num_pads = np[8:0]; start = 1'b1;
    @(negedge Clk);
    start = 1'b0; seed = '0; len = '0; num_pads = '0;
    while (!done) begin
      if (y_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        got_q.push_back(y);
      end
      if (y_last) begin
        last_idx = got_q.size();
        done = 1;
      end
      if (!busy) busy_bad = 1;
      x_valid = 1'b0; x = 1'b0;
      if (x_ready) begin
        if (!gap || (c % 3 == 0)) begin
          x_valid = 1'b1; x = psdu[di]; di++;
        end else begin
          n_idle++;
        end
      end
      if (glitch && c == 30) begin
        start = 1'b1; seed = 7'h01; len = 12'd3; num_pads = 9'd0;
      end else begin
        start = 1'b0; seed = '0; len = '0; num_pads = '0;
      end
      c++;
      if (c > 3000) begin
        timed_out = 1; done = 1;
      end
      @(negedge Clk);
    end
    start = 1'b0; x_valid = 1'b0;
    busy_after = busy;
  endtask

  task automatic build_exp(input logic [6:0] sd, input int ln, input int np);
    logic [6:0] s;
    bit f;
    exp_q.delete();
    s = (sd == 7'd0) ? 7'b1011101 : sd;
    for (int i = 0; i < 16 + ln + 6 + np; i++) begin
      f = s[6] ^ s[3];
      if (i < 16)           exp_q.push_back(f);
      else if (i < 16 + ln) exp_q.push_back(psdu[i-16] ^ f);
      else if (i < 22 + ln) exp_q.push_back(1'b0);
      else                  exp_q.push_back(f);
      s = {s[5:0], f};
    end
  endtask

  task automatic cmp_q(input string tag, input bit a[$], input bit b[$]);
    int e = 0;
    chk({tag, "_size"}, a.size(), b.size());
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] != b[i]) e++;
    chk({tag, "_bits"}, e, 0);
  endtask

  function automatic logic [63:0] pack(input int from, input int n);
    logic [63:0] v = '0;
    for (int i = from; i < from + n; i++)
      v = {v[62:0], (i < got_q.size()) ? got_q[i] : 1'b0};
    return v;
  endfunction

  task automatic frame_status(input string tag, input int exp_last);
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_last_at"}, last_idx, exp_last);
    chk({tag, "_busy_in_frame"}, busy_bad, 0);
    chk({tag, "_busy_drop"}, busy_after, 0);
  endtask

  logic [55:0] ref56;
  bit q0[$];
  logic [6:0] s;
  bit f;
  int errs;

  initial begin
    ref56 = 56'b00001110_11110010_11001001_00000010_00100110_00101110_10110110;
    for (int i = 0; i < 4096; i++) psdu[i] = 1'b0;

    repeat (3) @(negedge Clk);
    chk("reset_outputs", {x_ready, y, y_valid, y_last, busy}, 5'b0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle_outputs", {x_ready, y_valid, y_last, busy}, 4'b0);

    // len=0, num_pads=0
    run_frame(7'h7F, 0, 0, 0, 0);
    chk("t1_service", pack(0, 16), 64'(16'b0000111011110010));
    chk("t1_tail", pack(16, 6), 64'd0);
    chk("t1_count", got_q.size(), 22);
    frame_status("t1", 22);

    // started on the very cycle busy went low
    run_frame(7'h7F, 40, 3, 0, 0);
    chk("t2_seq56", pack(0, 56), 64'(ref56));
    chk("t2_tail", pack(56, 6), 64'd0);
    chk("t2_pads", pack(62, 3), 64'(3'b001));
    chk("t2_count", got_q.size(), 65);
    frame_status("t2", 65);
    ref_q = got_q;

    // 1,0,0 x_valid gaps plus an ignored start pulse mid-DATA
    run_frame(7'h7F, 40, 3, 1, 1);
    cmp_q("t3_vs_gapfree", got_q, ref_q);
    chk("t3_gaps_seen", n_idle > 0, 1);
    chk("t3_span", last_c - first_c + 1, 65 + n_idle);
    frame_status("t3", 65);
    @(negedge Clk);
    chk("t3_glitch_ignored", busy, 0);

    // zero seed falls back to 1011101
    psdu[0] = 1; psdu[1] = 0; psdu[2] = 1; psdu[3] = 0;
    psdu[4] = 0; psdu[5] = 1; psdu[6] = 0; psdu[7] = 1;
    run_frame(7'h00, 8, 2, 0, 0);
    q0 = got_q;
    frame_status("t4_seed0", 32);
    run_frame(7'b1011101, 8, 2, 0, 0);
    cmp_q("t4_seed0_vs_def", q0, got_q);
    build_exp(7'h00, 8, 2);
    cmp_q("t4_model", q0, exp_q);

    // loopback through a self-synchronising receiver descrambler
    for (int i = 0; i < 200; i++) psdu[i] = 1'($urandom_range(0, 1));
    run_frame(7'h35, 200, 5, 0, 0);
    frame_status("t5", 227);
    build_exp(7'h35, 200, 5);
    cmp_q("t5_model", got_q, exp_q);
    s = '0;
    for (int i = 0; i < 7; i++) s = {s[5:0], got_q[i]};
    errs = 0;
    for (int i = 7; i < 216 && i < got_q.size(); i++) begin
      f = s[6] ^ s[3];
      if (i < 16) begin
        if ((got_q[i] ^ f) != 1'b0) errs++;
      end else begin
        if ((got_q[i] ^ f) != psdu[i-16]) errs++;
      end
      s = {s[5:0], f};
    end
    chk("t5_loopback_errs", errs, 0);

    // async reset in the middle of DATA
    for (int i = 0; i < 200; i++) psdu[i] = 1'b0;
    seed = 7'h7F; len = 12'd40; num_pads = 9'd3; start = 1'b1;
    @(negedge Clk);
    start = 1'b0; seed = '0; len = '0; num_pads = '0;
    x = 1'b0; x_valid = 1'b1;
    repeat (20) @(negedge Clk);
    chk("t6_in_data", x_ready, 1);
    start = 1'b1; seed = 7'h01; len = 12'd2;
    @(negedge Clk);
    start = 1'b0; seed = '0; len = '0;
    #2 Reset = 1'b0;
    #1 chk("t6_async_clear", {x_ready, y, y_valid, y_last, busy}, 5'b0);
    @(negedge Clk);
    chk("t6_held_clear", {x_ready, y_valid, y_last, busy}, 4'b0);
    Reset = 1'b1; x_valid = 1'b0;
    @(negedge Clk);
    chk("t6_idle_after_release", {busy, y_valid, y_last}, 3'b0);
    run_frame(7'h7F, 0, 0, 0, 0);
    chk("t6_restart_service", pack(0, 16), 64'(16'b0000111011110010));
    chk("t6_restart_count", got_q.size(), 22);
    frame_status("t6", 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
